// File: rtl/store_route_buffer_pkg.sv
// -----------------------------------------------------------------------------
// store_route_buffer_pkg
// Shared constants for the store-side route buffer and the downstream
// demux_1to2: store data width, default MMIO region decode and the
// destination (sel) encoding both blocks agree on.
// -----------------------------------------------------------------------------
package store_route_buffer_pkg;

  localparam int STORE_DATA_W = 32;
  localparam int STORE_ADDR_W = 32;

  // Default MMIO window: any address whose upper half is all ones.
  localparam logic [STORE_ADDR_W-1:0] DEFAULT_MMIO_BASE = 32'hFFFF_0000;
  localparam logic [STORE_ADDR_W-1:0] DEFAULT_MMIO_MASK = 32'hFFFF_0000;

  // Destination encoding, identical to demux_1to2 sel.
  localparam logic DEST_DMEM = 1'b0;
  localparam logic DEST_MMIO = 1'b1;

endpackage : store_route_buffer_pkg

// File: rtl/store_route_buffer_sync_fifo.sv
// -----------------------------------------------------------------------------
// store_route_buffer_sync_fifo
// Single-clock in-order FIFO with occupancy count.
//   clk, rst_n      : clock, synchronous active-low reset (clears pointers/count)
//   push, wdata     : write request; ignored while full
//   pop             : read request; ignored while empty
//   rdata           : head entry (don't-care while empty)
//   count/full/empty: occupancy, derived only from registered state
// DEPTH must be a power of two >= 2 so pointers wrap for free.
// -----------------------------------------------------------------------------
module store_route_buffer_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];

  // Qualify requests here so the caller may push while full or pop while empty.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; its contents are only
  // observable behind count_q, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule : store_route_buffer_sync_fifo

// File: rtl/store_route_buffer.sv
// -----------------------------------------------------------------------------
// store_route_buffer
// In-order store queue in front of demux_1to2. Each accepted store is tagged at
// push time with its destination (dmem or MMIO) and presented one at a time.
//   clk, rst_n                 : clock, synchronous active-low reset
//   in_valid/in_ready          : store request handshake from MEM stage
//   in_addr, in_data           : store byte address and data
//   out_valid                  : head entry present
//   out_data/out_sel/out_addr  : head entry, all zero while empty
//   tgt_ready[0]/[1]           : dmem / MMIO can take the head this cycle
//   empty, full, count         : occupancy status for the hazard unit
// The head pops only when its own destination is ready; a stalled head blocks
// younger entries (no reordering between dmem and MMIO).
// -----------------------------------------------------------------------------
module store_route_buffer
  import store_route_buffer_pkg::*;
#(
  parameter int                DATA_W    = STORE_DATA_W,
  parameter int                ADDR_W    = STORE_ADDR_W,
  parameter int                DEPTH     = 4,
  parameter logic [ADDR_W-1:0] MMIO_BASE = ADDR_W'(DEFAULT_MMIO_BASE),
  parameter logic [ADDR_W-1:0] MMIO_MASK = ADDR_W'(DEFAULT_MMIO_MASK)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_sel,
  output logic [ADDR_W-1:0]        out_addr,
  input  logic [1:0]               tgt_ready,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int ENTRY_W = ADDR_W + DATA_W + 1;

  logic               in_sel;
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;
  logic               head_sel;
  logic               head_pop;
  logic               fifo_full, fifo_empty;

  // Destination is decided once, at push time, and travels with the entry.
  assign in_sel   = ((in_addr & MMIO_MASK) == MMIO_BASE) ? DEST_MMIO : DEST_DMEM;
  assign in_entry = {in_addr, in_data, in_sel};

  assign head_addr = head_entry[ENTRY_W-1 -: ADDR_W];
  assign head_data = head_entry[DATA_W:1];
  assign head_sel  = head_entry[0];

  // Only the head's own target matters; the other ready bit is ignored.
  assign head_pop = !fifo_empty && tgt_ready[head_sel];

  store_route_buffer_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .wdata (in_entry),
    .pop   (head_pop),
    .rdata (head_entry),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready = !fifo_full;
  assign full     = fifo_full;
  assign empty    = fifo_empty;

  // Storage is never reset, so the head is masked to zero whenever empty.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_sel   = DEST_DMEM;
    out_addr  = '0;
    if (!fifo_empty) begin
      out_valid = 1'b1;
      out_data  = head_data;
      out_sel   = head_sel;
      out_addr  = head_addr;
    end
  end

endmodule : store_route_buffer

// File: tb/tb_store_route_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_route_buffer
// Directed scenarios followed by randomized traffic, all compared cycle by
// cycle against a queue-based reference model of the store buffer.
// -----------------------------------------------------------------------------
module tb_store_route_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_sel;
  logic [31:0] out_addr;
  logic [1:0]  tgt_ready;
  logic        empty;
  logic        full;
  logic [2:0]  count;

  store_route_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_addr  (out_addr),
    .tgt_ready (tgt_ready),
    .empty     (empty),
    .full      (full),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        sel;
  } ent_t;

  ent_t        model_q[$];
  logic [31:0] popped[$];
  int          total = 0;
  int          bad   = 0;
  bit          last_push;

  // Reference decode: the MMIO window is the top 64 KiB of the address space.
  function automatic logic ref_sel(input logic [31:0] addr);
    return (addr >= 32'hFFFF_0000);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    logic [31:0] e_data, e_addr;
    logic        e_sel, e_valid;
    int          n;
    n       = model_q.size();
    e_valid = (n != 0);
    e_data  = e_valid ? model_q[0].data : 32'h0;
    e_addr  = e_valid ? model_q[0].addr : 32'h0;
    e_sel   = e_valid ? model_q[0].sel  : 1'b0;
    check({ctx, ":out_valid"}, 64'(out_valid), 64'(e_valid));
    check({ctx, ":out_data"},  64'(out_data),  64'(e_data));
    check({ctx, ":out_sel"},   64'(out_sel),   64'(e_sel));
    check({ctx, ":out_addr"},  64'(out_addr),  64'(e_addr));
    check({ctx, ":count"},     64'(count),     64'(n));
    check({ctx, ":empty"},     64'(empty),     64'(n == 0));
    check({ctx, ":full"},      64'(full),      64'(n == DEPTH));
    check({ctx, ":in_ready"},  64'(in_ready),  64'(n < DEPTH));
  endtask

  // Check the current state, clock one edge, then advance the model.
  task automatic cycle(input string ctx);
    bit   do_pop, do_push, rst_now;
    ent_t e;
    check_all(ctx);
    rst_now = !rst_n;
    do_pop  = model_q.size() > 0 && tgt_ready[model_q[0].sel];
    do_push = in_valid && model_q.size() < DEPTH;
    e.addr  = in_addr;
    e.data  = in_data;
    e.sel   = ref_sel(in_addr);
    @(posedge clk);
    #1;
    last_push = 1'b0;
    if (rst_now) begin
      model_q.delete();
    end else begin
      if (do_pop) begin
        popped.push_back(model_q[0].data);
        void'(model_q.pop_front());
      end
      if (do_push) begin
        model_q.push_back(e);
        last_push = 1'b1;
      end
    end
  endtask

  task automatic push_one(input logic [31:0] a, input logic [31:0] d, input string ctx);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    for (int i = 0; i < 20; i++) begin
      cycle(ctx);
      if (last_push) break;
    end
    check({ctx, ":accepted"}, 64'(last_push), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic check_popped(input string ctx, input logic [31:0] exp[$]);
    check({ctx, ":pop_count"}, 64'(popped.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < popped.size(); i++)
      check($sformatf("%s:pop%0d", ctx, i), 64'(popped[i]), 64'(exp[i]));
    popped.delete();
  endtask

  initial begin
    // 1. Reset with in_valid held high: nothing may be queued.
    rst_n = 1'b0; in_valid = 1'b1; in_addr = 32'h0000_0040;
    in_data = 32'h1234_5678; tgt_ready = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; in_valid = 1'b0;
    check("reset:count_direct", 64'(count), 64'(0));
    cycle("reset");
    cycle("reset_idle");

    // 2. Single dmem store pops immediately; MMIO store waits for bit1.
    tgt_ready = 2'b01;
    push_one(32'h0000_1000, 32'hDEAD_BEEF, "dmem");
    check("dmem:data_direct", 64'(out_data), 64'hDEAD_BEEF);
    check("dmem:sel_direct",  64'(out_sel),  64'(0));
    cycle("dmem_pop");
    check("dmem:empty_after", 64'(empty), 64'(1));
    push_one(32'hFFFF_0004, 32'hCAFE_0001, "mmio");
    repeat (3) cycle("mmio_hold");
    check("mmio:sel_direct", 64'(out_sel), 64'(1));
    tgt_ready = 2'b10;
    cycle("mmio_pop");
    check("mmio:empty_after", 64'(empty), 64'(1));
    popped.delete();

    // 3. Fill to full, fifth store held by the producer, then drain in order.
    tgt_ready = 2'b00;
    for (int i = 1; i <= 4; i++) push_one(32'h100 + 32'(4 * i), 32'(i), "fill");
    check("fill:full_direct", 64'(full), 64'(1));
    in_valid = 1'b1; in_addr = 32'h200; in_data = 32'h5;
    repeat (2) cycle("fill_blocked");
    tgt_ready = 2'b11;
    for (int i = 0; i < 8; i++) begin
      cycle("drain");
      if (last_push) in_valid = 1'b0;
    end
    check_popped("drain", '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5});

    // 4. Head-of-line blocking: MMIO head stalls a ready dmem entry behind it.
    tgt_ready = 2'b00;
    push_one(32'hFFFF_0010, 32'hA, "hol");
    push_one(32'h0000_0020, 32'hB, "hol");
    tgt_ready = 2'b01;
    repeat (5) cycle("hol_stall");
    check("hol:data_direct", 64'(out_data), 64'hA);
    tgt_ready = 2'b10;
    cycle("hol_pop_a");
    repeat (2) cycle("hol_hold_b");
    tgt_ready = 2'b01;
    cycle("hol_pop_b");
    check_popped("hol", '{32'hA, 32'hB});

    // 5. Simultaneous push/pop at count=2, then pop-while-full.
    tgt_ready = 2'b00;
    push_one(32'h300, 32'h11, "pp");
    push_one(32'h304, 32'h12, "pp");
    tgt_ready = 2'b01; in_valid = 1'b1; in_addr = 32'h308; in_data = 32'h13;
    cycle("pp_both");
    in_valid = 1'b0;
    check("pp:count_direct", 64'(count), 64'(2));
    tgt_ready = 2'b11;
    repeat (3) cycle("pp_drain");
    check_popped("pp", '{32'h11, 32'h12, 32'h13});
    tgt_ready = 2'b00;
    for (int i = 0; i < 4; i++) push_one(32'h400 + 32'(4 * i), 32'h20 + 32'(i), "pf");
    tgt_ready = 2'b01; in_valid = 1'b1; in_addr = 32'h500; in_data = 32'h99;
    cycle("pf_full_pop");
    check("pf:count_direct", 64'(count), 64'(3));
    check("pf:ready_direct", 64'(in_ready), 64'(1));
    cycle("pf_push");
    in_valid = 1'b0;
    tgt_ready = 2'b11;
    repeat (5) cycle("pf_drain");
    check_popped("pf", '{32'h20, 32'h21, 32'h22, 32'h23, 32'h99});

    // 6. Reset mid-drain with a concurrent push and pop.
    tgt_ready = 2'b00;
    for (int i = 0; i < 3; i++) push_one(32'h600 + 32'(4 * i), 32'h30 + 32'(i), "rm");
    rst_n = 1'b0; in_valid = 1'b1; in_addr = 32'h700; in_data = 32'h77; tgt_ready = 2'b11;
    cycle("rm_reset");
    rst_n = 1'b1; in_valid = 1'b0;
    check("rm:count_direct", 64'(count), 64'(0));
    repeat (3) cycle("rm_after");
    popped.delete();

    // Randomized traffic; producer holds a refused request until accepted.
    for (int i = 0; i < 600; i++) begin
      if (!(in_valid && !last_push && rst_n)) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_addr  = ($urandom_range(0, 1) != 0) ? {16'hFFFF, 16'($urandom)} : $urandom;
        in_data  = $urandom;
      end
      tgt_ready = 2'($urandom_range(0, 3));
      rst_n     = ($urandom_range(0, 59) != 0);
      cycle("rand");
    end
    rst_n = 1'b1; in_valid = 1'b0; tgt_ready = 2'b11;
    repeat (6) cycle("final_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_store_route_buffer
